// File: rtl/real_clock_pkg.sv
// ---------------------------------------------------------------------------
// real_clock_pkg
//   Shared definitions for the minute/second timing blocks: default field
//   width and upper limit, and the countdown timer state encoding.
// ---------------------------------------------------------------------------
package real_clock_pkg;

    // Default upper limit of a minute or second field (inclusive).
    localparam int MAX_VAL_DEF = 59;

    // Default width of a minute or second field.
    localparam int W_DEF = 6;

    // Countdown timer control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

endpackage : real_clock_pkg

// File: rtl/down_cnt60.sv
// ---------------------------------------------------------------------------
// down_cnt60
//   W-bit modulo-(MAX_VAL+1) down counter used for one time field.
//   Counts MAX_VAL, MAX_VAL-1, ..., 0, MAX_VAL, ... while enabled.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; clears the count to 0
//   en       in   decrement by one on this edge (wraps 0 -> MAX_VAL)
//   load     in   capture load_val (clamped to MAX_VAL); beats en
//   load_val in   W  preset value
//   q        out  W  current count, registered
//   borrow   out  count is at 0: the next enabled step wraps and must
//                 borrow from the next more significant field
// ---------------------------------------------------------------------------
module down_cnt60
    import real_clock_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         borrow
);

    localparam logic [W-1:0] MAX_Q = W'(MAX_VAL);

    logic [W-1:0] load_clamped;

    // Out-of-range presets saturate so the field can never hold a value
    // above MAX_VAL.
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    assign borrow = (q == '0);

    // NOTE: registered state is written with <= so every flop samples the
    // pre-edge values; blocking = here would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (en) begin
            q <= borrow ? MAX_Q : (q - W'(1));
        end
    end

endmodule : down_cnt60

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   Minutes:seconds countdown timer driven by a one-cycle 1 Hz tick.
//   A preset is loaded, started, optionally paused/resumed, and counts down
//   to 00:00, where it raises a one-cycle done pulse and holds expired until
//   acknowledged. Per-cycle priority: reset > load > ack > pause > start >
//   tick; a strobe that has no effect in the current state falls through to
//   the next one.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   tc_time_base  in   one-cycle 1 Hz tick strobe
//   load          in   capture load_minutes/load_seconds, go IDLE
//   load_minutes  in   W  preset minutes (clamped to MAX_VAL)
//   load_seconds  in   W  preset seconds (clamped to MAX_VAL)
//   start         in   begin/resume from IDLE or PAUSE when count non-zero
//   pause         in   freeze a running countdown
//   ack           in   clear expiry (EXPIRED -> IDLE)
//   q_minutes     out  W  remaining minutes, registered
//   q_seconds     out  W  remaining seconds, registered
//   running       out  high while in RUN
//   expired       out  high while in EXPIRED
//   done          out  one-cycle pulse on the edge that writes 00:00
// ---------------------------------------------------------------------------
module countdown_timer
    import real_clock_pkg::*;
#(
    parameter int MAX_VAL = MAX_VAL_DEF,
    parameter int W       = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tc_time_base,
    input  logic         load,
    input  logic [W-1:0] load_minutes,
    input  logic [W-1:0] load_seconds,
    input  logic         start,
    input  logic         pause,
    input  logic         ack,
    output logic [W-1:0] q_minutes,
    output logic [W-1:0] q_seconds,
    output logic         running,
    output logic         expired,
    output logic         done
);

    state_t state, state_next;

    logic dec_en;       // decrement the count on this edge
    logic reach_zero;   // this decrement lands on 00:00
    logic sec_zero;
    logic min_zero;
    logic count_zero;
    logic one_left;     // count is exactly 00:01

    assign count_zero = sec_zero & min_zero;
    assign one_left   = min_zero & (q_seconds == W'(1));

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        dec_en     = 1'b0;
        reach_zero = 1'b0;

        if (load) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !count_zero) state_next = RUN;
                end
                RUN: begin
                    // ack and start are meaningless here, so pause and
                    // then the tick decide; a paused tick is dropped.
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (tc_time_base) begin
                        dec_en = 1'b1;
                        if (one_left) begin
                            state_next = EXPIRED;
                            reach_zero = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start && !count_zero) state_next = RUN;
                end
                EXPIRED: begin
                    if (ack) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= reach_zero;
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

    // ------------------------------------------------------------------
    // Field counters: seconds borrows into minutes. RUN never holds 00:00,
    // so the minutes field never wraps below zero.
    // ------------------------------------------------------------------
    down_cnt60 #(
        .W       (W),
        .MAX_VAL (MAX_VAL)
    ) u_seconds (
        .clk      (clk),
        .reset    (reset),
        .en       (dec_en),
        .load     (load),
        .load_val (load_seconds),
        .q        (q_seconds),
        .borrow   (sec_zero)
    );

    down_cnt60 #(
        .W       (W),
        .MAX_VAL (MAX_VAL)
    ) u_minutes (
        .clk      (clk),
        .reset    (reset),
        .en       (dec_en & sec_zero),
        .load     (load),
        .load_val (load_minutes),
        .q        (q_minutes),
        .borrow   (min_zero)
    );

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Self-checking bench for countdown_timer. The reference model keeps the
//   remaining time as a single number of seconds and splits it into fields
//   only for comparison. Built with W=7 so over-range presets such as 75
//   can be presented literally.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int W    = 7;
    localparam int MAXV = 59;
    localparam int BASE = MAXV + 1;

    logic         clk;
    logic         reset;
    logic         tc_time_base;
    logic         load;
    logic [W-1:0] load_minutes;
    logic [W-1:0] load_seconds;
    logic         start;
    logic         pause;
    logic         ack;
    logic [W-1:0] q_minutes;
    logic [W-1:0] q_seconds;
    logic         running;
    logic         expired;
    logic         done;

    countdown_timer #(
        .MAX_VAL (MAXV),
        .W       (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tc_time_base (tc_time_base),
        .load         (load),
        .load_minutes (load_minutes),
        .load_seconds (load_seconds),
        .start        (start),
        .pause        (pause),
        .ack          (ack),
        .q_minutes    (q_minutes),
        .q_seconds    (q_seconds),
        .running      (running),
        .expired      (expired),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mode_e;

    mode_e m_mode;
    int    m_total;       // remaining time in seconds
    bit    m_done;
    bit    model_valid;

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Applies the inputs present at this edge to the model.
    task automatic model_step();
        m_done = 1'b0;
        if (reset) begin
            m_total = 0;
            m_mode  = M_IDLE;
        end else if (load) begin
            m_total = clamp(int'(load_minutes)) * BASE + clamp(int'(load_seconds));
            m_mode  = M_IDLE;
        end else if (ack && m_mode == M_EXPIRED) begin
            m_mode = M_IDLE;
        end else if (pause && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_total > 0) begin
            m_mode = M_RUN;
        end else if (tc_time_base && m_mode == M_RUN) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_mode = M_EXPIRED;
                m_done = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("q_minutes", 32'(q_minutes), 32'(m_total / BASE));
            check("q_seconds", 32'(q_seconds), 32'(m_total % BASE));
            check("running",   32'(running),   32'(m_mode == M_RUN));
            check("expired",   32'(expired),   32'(m_mode == M_EXPIRED));
            check("done",      32'(done),      32'(m_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge, are sampled by
    // the DUT and the model on the rising edge, and the task returns on
    // the following falling edge.
    // ------------------------------------------------------------------
    task automatic cyc(input bit r, input bit l, input int lm, input int ls,
                       input bit s, input bit p, input bit a, input bit t);
        reset        = r;
        load         = l;
        load_minutes = lm[W-1:0];
        load_seconds = ls[W-1:0];
        start        = s;
        pause        = p;
        ack          = a;
        tc_time_base = t;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_idle();            cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();           cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_load(input int m, input int s); cyc(0, 1, m, s, 0, 0, 0, 0); endtask
    task automatic do_start();           cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_tick();            cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic do_ack();             cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask

    task automatic pin_out(input string tag, input int mm, input int ss,
                           input bit run, input bit exp, input bit dn);
        check({tag, ".min"},     32'(q_minutes), 32'(mm));
        check({tag, ".sec"},     32'(q_seconds), 32'(ss));
        check({tag, ".running"}, 32'(running),   32'(run));
        check({tag, ".expired"}, 32'(expired),   32'(exp));
        check({tag, ".done"},    32'(done),      32'(dn));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_valid = 1'b0;
        m_mode      = M_IDLE;
        m_total     = 0;
        m_done      = 1'b0;

        do_reset();
        do_reset();
        model_valid = 1'b1;
        pin_out("reset", 0, 0, 0, 0, 0);

        // Three-second countdown to expiry.
        do_load(0, 3);
        pin_out("load003", 0, 3, 0, 0, 0);
        do_start();
        pin_out("start003", 0, 3, 1, 0, 0);
        do_tick();
        pin_out("tick1", 0, 2, 1, 0, 0);
        do_tick();
        pin_out("tick2", 0, 1, 1, 0, 0);
        do_tick();
        pin_out("tick3", 0, 0, 0, 1, 1);
        do_idle();
        pin_out("after_done", 0, 0, 0, 1, 0);

        // Ticks while expired do nothing; ack returns to idle at 00:00.
        for (int i = 0; i < 5; i++) do_tick();
        pin_out("exp_ticks", 0, 0, 0, 1, 0);
        do_ack();
        pin_out("ack", 0, 0, 0, 0, 0);
        do_start();
        pin_out("start_zero", 0, 0, 0, 0, 0);

        // Minute borrow and preset clamping.
        do_load(2, 0);
        do_start();
        do_tick();
        pin_out("borrow", 1, 59, 1, 0, 0);
        do_load(60, 75);
        pin_out("clamp", 59, 59, 0, 0, 0);

        // Pause beats a coincident tick; resume then tick.
        do_load(0, 10);
        do_start();
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        pin_out("pause_tick", 0, 10, 0, 0, 0);
        do_start();
        pin_out("resume", 0, 10, 1, 0, 0);
        do_tick();
        pin_out("resume_tick", 0, 9, 1, 0, 0);

        // Reset aborts a running countdown without a done pulse.
        do_load(1, 30);
        do_start();
        do_reset();
        pin_out("reset_run", 0, 0, 0, 0, 0);
        do_idle();
        pin_out("reset_after", 0, 0, 0, 0, 0);

        // Load wins over ack while expired.
        do_load(0, 1);
        do_start();
        do_tick();
        pin_out("exp1", 0, 0, 0, 1, 1);
        cyc(0, 1, 3, 4, 0, 0, 1, 0);
        pin_out("load_ack", 3, 4, 0, 0, 0);

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            int lm, ls;
            lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, 1));
            ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                              : int'($urandom_range(0, 6));
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 39) == 0,
                lm, ls,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 0);
        end

        do_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_timer
